// File: rtl/mwdatabus_ctrl.sv
// Write data-bus controller: routes one write request to REG, ROM/RAM or IO,
// sequencing strobes, memory wait states and IO acknowledge with timeout.
module mwdatabus_ctrl #(
    parameter int unsigned MEM_WAIT   = 2,
    parameter int unsigned IO_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    input  logic [15:0] DST,
    input  logic [15:0] DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] REG_WD,
    output logic        REG_WE,
    output logic [15:0] MEM_WD,
    output logic        MEM_WE,
    output logic [15:0] IO_WD,
    output logic        IO_WE,
    input  logic        IO_ACK
);

    typedef enum logic [2:0] {
        IDLE,
        REG_WR,
        MEM_WR,
        IO_WR,
        FIN
    } state_t;

    localparam logic [7:0] MEM_LAST = 8'(MEM_WAIT - 1);
    localparam logic [7:0] IO_LAST  = 8'(IO_TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;

    // Only the target select bits of the destination word matter.
    logic unused_dst;
    assign unused_dst = ^DST[15:2];

    // Transfer sequencer; every output is a register updated here.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            ERR    <= 1'b0;
            REG_WE <= 1'b0;
            REG_WD <= 16'h0000;
            MEM_WE <= 1'b0;
            MEM_WD <= 16'h0000;
            IO_WE  <= 1'b0;
            IO_WD  <= 16'h0000;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            unique case (state)
                IDLE, FIN: begin
                    BUSY <= 1'b0;
                    if (REQ) begin
                        BUSY <= 1'b1;
                        cnt  <= 8'd0;
                        unique case (DST[1:0])
                            2'b00: begin
                                state  <= REG_WR;
                                REG_WE <= 1'b1;
                                REG_WD <= DATA;
                            end
                            2'b01: begin
                                state  <= MEM_WR;
                                MEM_WE <= 1'b1;
                                MEM_WD <= DATA;
                            end
                            2'b10: begin
                                state <= IO_WR;
                                IO_WE <= 1'b1;
                                IO_WD <= DATA;
                            end
                            default: begin
                                // Null sink: one busy cycle, no strobe.
                                state <= REG_WR;
                            end
                        endcase
                    end else begin
                        state <= IDLE;
                    end
                end
                REG_WR: begin
                    state  <= FIN;
                    BUSY   <= 1'b0;
                    DONE   <= 1'b1;
                    REG_WE <= 1'b0;
                    REG_WD <= 16'h0000;
                end
                MEM_WR: begin
                    if (cnt == MEM_LAST) begin
                        state  <= FIN;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        MEM_WE <= 1'b0;
                        MEM_WD <= 16'h0000;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                IO_WR: begin
                    // An ACK in the last allowed cycle still wins.
                    if (IO_ACK || cnt == IO_LAST) begin
                        state <= FIN;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        ERR   <= ~IO_ACK;
                        IO_WE <= 1'b0;
                        IO_WD <= 16'h0000;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mwdatabus_ctrl.sv
// Directed bench for mwdatabus_ctrl: cycle vector table plus
// hand sequences for IO timeout, late ACK and mid-transfer reset.
module tb_mwdatabus_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        REQ;
    logic [15:0] DST;
    logic [15:0] DATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [15:0] REG_WD;
    logic        REG_WE;
    logic [15:0] MEM_WD;
    logic        MEM_WE;
    logic [15:0] IO_WD;
    logic        IO_WE;
    logic        IO_ACK;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        rwe;
        logic [15:0] rwd;
        logic        mwe;
        logic [15:0] mwd;
        logic        iwe;
        logic [15:0] iwd;
    } out_t;

    typedef struct packed {
        logic        req;
        logic [15:0] dst;
        logic [15:0] data;
        logic        ack;
        out_t        exp;
    } vec_t;

    int checks;
    int failures;

    mwdatabus_ctrl #(
        .MEM_WAIT(2),
        .IO_TIMEOUT(15)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .REQ(REQ),
        .DST(DST),
        .DATA(DATA),
        .BUSY(BUSY),
        .DONE(DONE),
        .ERR(ERR),
        .REG_WD(REG_WD),
        .REG_WE(REG_WE),
        .MEM_WD(MEM_WD),
        .MEM_WE(MEM_WE),
        .IO_WD(IO_WD),
        .IO_WE(IO_WE),
        .IO_ACK(IO_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic out_t o(
        input logic b, input logic d, input logic e,
        input logic rw, input logic [15:0] rd,
        input logic mw, input logic [15:0] md,
        input logic iw, input logic [15:0] id
    );
        out_t r;
        r.busy = b; r.done = d; r.err = e;
        r.rwe = rw; r.rwd = rd;
        r.mwe = mw; r.mwd = md;
        r.iwe = iw; r.iwd = id;
        return r;
    endfunction

    function automatic vec_t v(
        input logic req, input logic [15:0] dst,
        input logic [15:0] data, input logic ack, input out_t e
    );
        vec_t r;
        r.req = req; r.dst = dst; r.data = data;
        r.ack = ack; r.exp = e;
        return r;
    endfunction

    function automatic out_t actual();
        return o(BUSY, DONE, ERR, REG_WE, REG_WD,
                 MEM_WE, MEM_WD, IO_WE, IO_WD);
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = actual();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs at negedge, sample 1 time unit after the next posedge.
    task automatic cycle(
        input logic req, input logic [15:0] dst,
        input logic [15:0] data, input logic ack
    );
        @(negedge CLK);
        REQ = req; DST = dst; DATA = data; IO_ACK = ack;
        @(posedge CLK);
        #1;
    endtask

    out_t z;
    vec_t tbl[23];

    initial begin
        checks   = 0;
        failures = 0;
        z = o(0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0);

        tbl[0]  = v(1, 16'h0000, 16'hA55A, 0,
                    o(1,0,0, 1,16'hA55A, 0,16'h0, 0,16'h0));
        tbl[1]  = v(0, 16'h0000, 16'h0000, 0, o(0,1,0, 0,0, 0,0, 0,0));
        tbl[2]  = v(0, 16'h0000, 16'h0000, 0, z);
        tbl[3]  = v(1, 16'hFFF1, 16'h1234, 0,
                    o(1,0,0, 0,16'h0, 1,16'h1234, 0,16'h0));
        tbl[4]  = v(0, 16'h0000, 16'h0000, 0,
                    o(1,0,0, 0,16'h0, 1,16'h1234, 0,16'h0));
        tbl[5]  = v(0, 16'h0000, 16'h0000, 0, o(0,1,0, 0,0, 0,0, 0,0));
        tbl[6]  = v(0, 16'h0000, 16'h0000, 0, z);
        tbl[7]  = v(1, 16'h0002, 16'hBEEF, 0,
                    o(1,0,0, 0,16'h0, 0,16'h0, 1,16'hBEEF));
        tbl[8]  = v(0, 16'h0000, 16'h0000, 0,
                    o(1,0,0, 0,16'h0, 0,16'h0, 1,16'hBEEF));
        tbl[9]  = v(0, 16'h0000, 16'h0000, 0,
                    o(1,0,0, 0,16'h0, 0,16'h0, 1,16'hBEEF));
        tbl[10] = v(0, 16'h0000, 16'h0000, 1, o(0,1,0, 0,0, 0,0, 0,0));
        tbl[11] = v(0, 16'h0000, 16'h0000, 1, z);
        tbl[12] = v(1, 16'h0003, 16'h7777, 0, o(1,0,0, 0,0, 0,0, 0,0));
        tbl[13] = v(0, 16'h0000, 16'h0000, 0, o(0,1,0, 0,0, 0,0, 0,0));
        tbl[14] = v(0, 16'h0000, 16'h0000, 0, z);
        tbl[15] = v(1, 16'h0000, 16'h1111, 0,
                    o(1,0,0, 1,16'h1111, 0,16'h0, 0,16'h0));
        tbl[16] = v(1, 16'h0002, 16'h2222, 0, o(0,1,0, 0,0, 0,0, 0,0));
        tbl[17] = v(1, 16'h0002, 16'h2222, 0,
                    o(1,0,0, 0,16'h0, 0,16'h0, 1,16'h2222));
        tbl[18] = v(1, 16'h0000, 16'h3333, 0,
                    o(1,0,0, 0,16'h0, 0,16'h0, 1,16'h2222));
        tbl[19] = v(1, 16'h0000, 16'h3333, 1, o(0,1,0, 0,0, 0,0, 0,0));
        tbl[20] = v(1, 16'h0000, 16'h3333, 0,
                    o(1,0,0, 1,16'h3333, 0,16'h0, 0,16'h0));
        tbl[21] = v(0, 16'h0000, 16'h0000, 0, o(0,1,0, 0,0, 0,0, 0,0));
        tbl[22] = v(0, 16'h0000, 16'h0000, 0, z);

        RST_N = 1'b0; REQ = 1'b0; DST = 16'h0;
        DATA = 16'h0; IO_ACK = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset", z);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 23; i++) begin
            cycle(tbl[i].req, tbl[i].dst, tbl[i].data, tbl[i].ack);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // IO timeout: 15 strobe cycles, then DONE with ERR.
        cycle(1, 16'h0002, 16'hCAFE, 0);
        check("to_we1", o(1,0,0, 0,0, 0,0, 1,16'hCAFE));
        for (int i = 2; i <= 15; i++) begin
            cycle(0, 16'h0, 16'h0, 0);
            check($sformatf("to_we%0d", i),
                  o(1,0,0, 0,0, 0,0, 1,16'hCAFE));
        end
        cycle(0, 16'h0, 16'h0, 0);
        check("to_err", o(0,1,1, 0,0, 0,0, 0,0));
        cycle(0, 16'h0, 16'h0, 0);
        check("to_idle", z);

        // ACK only in the 15th strobe cycle counts as success.
        cycle(1, 16'h0002, 16'h0F0F, 0);
        for (int i = 2; i <= 15; i++) begin
            cycle(0, 16'h0, 16'h0, 0);
        end
        check("late_we15", o(1,0,0, 0,0, 0,0, 1,16'h0F0F));
        cycle(0, 16'h0, 16'h0, 1);
        check("late_ok", o(0,1,0, 0,0, 0,0, 0,0));
        cycle(0, 16'h0, 16'h0, 0);

        // Asynchronous reset during the second MEM strobe cycle.
        cycle(1, 16'h0001, 16'h5A5A, 0);
        cycle(0, 16'h0, 16'h0, 0);
        check("rst_mem2", o(1,0,0, 0,0, 1,16'h5A5A, 0,0));
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_async", z);
        @(posedge CLK);
        #1;
        check("rst_hold", z);
        @(negedge CLK);
        RST_N = 1'b1;
        cycle(0, 16'h0, 16'h0, 0);
        check("rst_nodone", z);
        cycle(1, 16'h0000, 16'h9999, 0);
        check("rst_fresh", o(1,0,0, 1,16'h9999, 0,0, 0,0));
        cycle(0, 16'h0, 16'h0, 0);
        check("rst_done", o(0,1,0, 0,0, 0,0, 0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mwdatabus_ctrl.md
Name: mwdatabus_ctrl

Overview:
- Write-direction counterpart of the read data-bus multiplexer.
- Accepts one write request at a time: 16-bit data plus a 16-bit destination word.
- Decodes DST[1:0] into one of three targets (register file, ROM/RAM, IO) or a null sink.
- Sequences the target's write strobe, including ROM/RAM wait states and IO acknowledge handshake with timeout, then signals completion.

Parameters:
- MEM_WAIT, 2, cycles MEM_WE is held per ROM/RAM write (legal range 1..15).
- IO_TIMEOUT, 15, max cycles IO_WE is held waiting for IO_ACK before aborting (legal range 1..255).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- REQ  input  1  write request, sampled when BUSY=0.
- DST  input  16  destination word; bits[1:0]: 00=REG, 01=ROM_RAM, 10=IO, 11=null; bits[15:2] ignored.
- DATA  input  16  write data.
- BUSY  output  1  transfer in progress; REQ ignored while high.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  one-cycle pulse coincident with DONE on IO timeout.
- REG_WD  output  16  register-file write data.
- REG_WE  output  1  register-file write enable.
- MEM_WD  output  16  ROM/RAM write data.
- MEM_WE  output  1  ROM/RAM write enable.
- IO_WD  output  16  IO write data.
- IO_WE  output  1  IO write enable.
- IO_ACK  input  1  IO write acknowledge.

Behaviour:
- All outputs are registered.
- Reset (RST_N=0, asynchronous): state IDLE; BUSY, DONE, ERR, all WE = 0; all WD = 16'h0000; counters = 0. Reset mid-transfer drops any active WE immediately; the transfer is lost, with no DONE.
- States: IDLE, REG_WR, MEM_WR, IO_WR, FIN.
- Acceptance: in IDLE or FIN, REQ=1 at edge N latches DST[1:0] and DATA. BUSY=1 from cycle N+1.
- REG_WR: REG_WE=1 and REG_WD=data for exactly 1 cycle (N+1), then FIN.
- MEM_WR: MEM_WE=1 and MEM_WD=data for MEM_WAIT cycles (N+1 .. N+MEM_WAIT), then FIN.
- IO_WR:
  - IO_WE=1 and IO_WD=data from N+1.
  - Each cycle IO_WE is high, IO_ACK is sampled. If IO_ACK=1, the current cycle is the last IO_WE cycle, then FIN.
  - If IO_TIMEOUT cycles elapse without IO_ACK, IO_WE drops, then FIN with ERR=1.
  - IO_ACK=1 in the final timeout cycle counts as success, not an error.
- Null (DST[1:0]=11): no WE asserted; BUSY=1 for cycle N+1 only, then FIN.
- FIN (1 cycle): DONE=1, BUSY=0, ERR as set by IO_WR, all WE=0. REQ=1 in FIN is accepted exactly as in IDLE (back-to-back transfers). With no REQ, return to IDLE.
- WD outputs equal the latched data only while the matching WE=1; otherwise 16'h0000.
- At most one WE is high in any cycle.
- IO_ACK is ignored outside IO_WR.
- REQ while BUSY=1 is dropped, not queued; DST and DATA changes while BUSY=1 have no effect.
- Timeout counter is 8 bits and clears on every acceptance.

Test Plan:
- Reset then REQ with DST=16'h0000, DATA=16'hA55A -> REG_WE=1, REG_WD=A55A for 1 cycle; DONE the next cycle; ERR=0; MEM_WE=IO_WE=0 throughout.
- DST=16'hFFF1 (upper bits set), DATA=16'h1234, MEM_WAIT=2 -> MEM_WE high 2 cycles with MEM_WD=1234; DONE on the 3rd cycle after acceptance.
- DST=16'h0002, DATA=16'hBEEF, IO_ACK raised in the 3rd IO_WE cycle -> IO_WE high exactly 3 cycles; DONE=1 and ERR=0 the following cycle.
- DST=16'h0002, IO_ACK held 0, IO_TIMEOUT=15 -> IO_WE high 15 cycles, then DONE=1 and ERR=1 together for 1 cycle; separately, IO_ACK=1 only in cycle 15 -> ERR=0.
- DST=16'h0003 -> no WE ever asserted, DONE 2 cycles after acceptance. Then REQ held high continuously with alternating REG and IO writes -> each new transfer is accepted in the FIN cycle, REQs during BUSY are dropped, and WEs are never concurrent.
- RST_N pulsed low during the 2nd MEM_WE cycle -> MEM_WE, BUSY and MEM_WD go to 0 asynchronously; no DONE; a fresh REQ after release completes normally.
